// File: rtl/dmem_req_arbiter.sv
// Round-robin data-memory request controller: NUM_CH_P requesters share one
// memory port, one outstanding request at a time, with a sticky response timeout.
module dmem_req_arbiter #(
    parameter int unsigned NUM_CH_P     = 3,
    parameter int unsigned DATA_WIDTH_P = 32,
    parameter int unsigned ADDR_WIDTH_P = 12,
    parameter int unsigned TIMEOUT_P    = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CH_P-1:0]              ch_valid_i,
    input  logic [NUM_CH_P-1:0]              ch_wen_i,
    input  logic [NUM_CH_P-1:0]              ch_byte_not_word_i,
    input  logic [NUM_CH_P*ADDR_WIDTH_P-1:0] ch_addr_i,
    input  logic [NUM_CH_P*DATA_WIDTH_P-1:0] ch_wdata_i,
    output logic [NUM_CH_P-1:0]              ch_yumi_o,
    output logic [NUM_CH_P-1:0]              ch_rvalid_o,
    output logic [DATA_WIDTH_P-1:0]          ch_rdata_o,
    output logic                             mem_valid_o,
    output logic                             mem_wen_o,
    output logic                             mem_byte_not_word_o,
    output logic [ADDR_WIDTH_P-1:0]          mem_addr_o,
    output logic [DATA_WIDTH_P-1:0]          mem_wdata_o,
    input  logic                             mem_yumi_i,
    input  logic                             mem_rvalid_i,
    input  logic [DATA_WIDTH_P-1:0]          mem_rdata_i,
    output logic                             mem_yumi_o,
    output logic                             busy_o,
    output logic [$clog2(NUM_CH_P)-1:0]      grant_id_o,
    output logic                             err_o
);

    localparam int unsigned GW = $clog2(NUM_CH_P);
    localparam int unsigned TW = (TIMEOUT_P > 1) ? $clog2(TIMEOUT_P) : 1;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_REQ_SENT,
        DMEM_REQ_ACKED
    } state_t;

    state_t                  r_state;
    logic [GW-1:0]           r_last;
    logic [GW-1:0]           r_grant;
    logic [TW-1:0]           r_timer;
    logic                    r_err;
    logic                    r_wen;
    logic                    r_bnw;
    logic [ADDR_WIDTH_P-1:0] r_addr;
    logic [DATA_WIDTH_P-1:0] r_wdata;

    logic [NUM_CH_P-1:0]     w_hi;
    logic [GW-1:0]           w_sel;
    logic                    w_grant;
    logic                    w_done;
    logic                    w_wen;
    logic                    w_bnw;
    logic [ADDR_WIDTH_P-1:0] w_addr;
    logic [DATA_WIDTH_P-1:0] w_wdata;

    // Round-robin pick: lowest valid channel above last_grant, else lowest valid overall
    always_comb begin
        w_hi  = '0;
        w_sel = '0;
        for (int i = 0; i < int'(NUM_CH_P); i++) begin
            w_hi[i] = ch_valid_i[i] && (GW'(i) > r_last);
        end
        for (int i = int'(NUM_CH_P) - 1; i >= 0; i--) begin
            if (ch_valid_i[i]) w_sel = GW'(i);
        end
        for (int i = int'(NUM_CH_P) - 1; i >= 0; i--) begin
            if (w_hi[i]) w_sel = GW'(i);
        end
    end

    assign w_grant = !reset && (r_state == DMEM_IDLE) && (|ch_valid_i);

    always_comb begin
        w_wen   = 1'b0;
        w_bnw   = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < int'(NUM_CH_P); i++) begin
            if (GW'(i) == w_sel) begin
                w_wen   = ch_wen_i[i];
                w_bnw   = ch_byte_not_word_i[i];
                w_addr  = ch_addr_i[i*ADDR_WIDTH_P +: ADDR_WIDTH_P];
                w_wdata = ch_wdata_i[i*DATA_WIDTH_P +: DATA_WIDTH_P];
            end
        end
    end

    assign w_done = !reset &&
                    (((r_state == DMEM_REQ_SENT) && mem_yumi_i && mem_rvalid_i) ||
                     ((r_state == DMEM_REQ_ACKED) && mem_rvalid_i));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= DMEM_IDLE;
            r_last  <= GW'(NUM_CH_P - 1);
            r_grant <= '0;
            r_timer <= '0;
            r_err   <= 1'b0;
            r_wen   <= 1'b0;
            r_bnw   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                DMEM_IDLE: begin
                    if (w_grant) begin
                        r_wen   <= w_wen;
                        r_bnw   <= w_bnw;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_grant <= w_sel;
                        r_last  <= w_sel;
                        r_state <= DMEM_REQ_SENT;
                    end
                end
                DMEM_REQ_SENT: begin
                    if (mem_yumi_i) begin
                        if (mem_rvalid_i) begin
                            r_state <= DMEM_IDLE;
                        end else begin
                            r_timer <= '0;
                            r_state <= DMEM_REQ_ACKED;
                        end
                    end
                end
                DMEM_REQ_ACKED: begin
                    r_timer <= r_timer + TW'(1);
                    if (mem_rvalid_i) begin
                        r_state <= DMEM_IDLE;
                    end else if ((TIMEOUT_P != 0) && (r_timer == TW'(TIMEOUT_P - 1))) begin
                        r_err   <= 1'b1;
                        r_state <= DMEM_IDLE;
                    end
                end
                default: r_state <= DMEM_IDLE;
            endcase
        end
    end

    // Accept/response strobes are combinational with the memory handshake
    always_comb begin
        ch_yumi_o   = '0;
        ch_rvalid_o = '0;
        for (int i = 0; i < int'(NUM_CH_P); i++) begin
            ch_yumi_o[i]   = w_grant && (GW'(i) == w_sel);
            ch_rvalid_o[i] = w_done && (GW'(i) == r_grant);
        end
    end

    always_comb begin
        ch_rdata_o = '0;
        if (w_done) begin
            ch_rdata_o = r_bnw ? DATA_WIDTH_P'(mem_rdata_i[7:0]) : mem_rdata_i;
        end
    end

    // Stray responses in IDLE are drained so memory never stalls
    assign mem_yumi_o          = w_done || (!reset && (r_state == DMEM_IDLE) && mem_rvalid_i);
    assign mem_valid_o         = (r_state == DMEM_REQ_SENT);
    assign mem_wen_o           = r_wen;
    assign mem_byte_not_word_o = r_bnw;
    assign mem_addr_o          = r_addr;
    assign mem_wdata_o         = r_wdata;
    assign busy_o              = (r_state != DMEM_IDLE);
    assign grant_id_o          = r_grant;
    assign err_o               = r_err;

endmodule

// File: tb/tb_dmem_req_arbiter.sv
// Scoreboard bench for dmem_req_arbiter: expected responses queued when the
// memory reply is driven, popped when ch_rvalid_o pulses.
module tb_dmem_req_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  ch_valid;
    logic [2:0]  ch_wen;
    logic [2:0]  ch_bnw;
    logic [35:0] ch_addr;
    logic [95:0] ch_wdata;
    logic [2:0]  ch_yumi_o;
    logic [2:0]  ch_rvalid_o;
    logic [31:0] ch_rdata_o;
    logic        mem_valid_o;
    logic        mem_wen_o;
    logic        mem_bnw_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_yumi_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_yumi_o;
    logic        busy_o;
    logic [1:0]  grant_id_o;
    logic        err_o;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    logic [2:0] prev_yumi;
    int   n_checks;
    int   n_fail;

    dmem_req_arbiter #(
        .NUM_CH_P(3), .DATA_WIDTH_P(32), .ADDR_WIDTH_P(12), .TIMEOUT_P(4)
    ) dut (
        .clk                 (clk),
        .reset               (rst),
        .ch_valid_i          (ch_valid),
        .ch_wen_i            (ch_wen),
        .ch_byte_not_word_i  (ch_bnw),
        .ch_addr_i           (ch_addr),
        .ch_wdata_i          (ch_wdata),
        .ch_yumi_o           (ch_yumi_o),
        .ch_rvalid_o         (ch_rvalid_o),
        .ch_rdata_o          (ch_rdata_o),
        .mem_valid_o         (mem_valid_o),
        .mem_wen_o           (mem_wen_o),
        .mem_byte_not_word_o (mem_bnw_o),
        .mem_addr_o          (mem_addr_o),
        .mem_wdata_o         (mem_wdata_o),
        .mem_yumi_i          (mem_yumi_i),
        .mem_rvalid_i        (mem_rvalid_i),
        .mem_rdata_i         (mem_rdata_i),
        .mem_yumi_o          (mem_yumi_o),
        .busy_o              (busy_o),
        .grant_id_o          (grant_id_o),
        .err_o               (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Output monitor: grant log, pulse-width check, scoreboard pop
    always @(negedge clk) begin
        #4;
        if (ch_yumi_o != 3'b000) begin
            chk("yumi_pulse", 32'(prev_yumi), 32'h0);
            chk("yumi_onehot", 32'($countones(ch_yumi_o)), 32'h1);
            for (int i = 0; i < 3; i++) if (ch_yumi_o[i]) grant_log.push_back(i);
        end
        prev_yumi = ch_yumi_o;
        if (ch_rvalid_o != 3'b000) begin
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", 32'(ch_rvalid_o), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rvalid_ch", 32'(ch_rvalid_o), 32'(3'b001 << e.ch));
                chk("rdata", ch_rdata_o, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_mv(input string tag);
        int n;
        n = 0;
        while (mem_valid_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (mem_valid_o !== 1'b1) chk(tag, 32'(mem_valid_o), 32'h1);
    endtask

    task automatic issue(input int ch, input logic wen, input logic bnw,
                         input logic [11:0] addr, input logic [31:0] wdata);
        ch_valid[ch]           = 1'b1;
        ch_wen[ch]             = wen;
        ch_bnw[ch]             = bnw;
        ch_addr[ch*12 +: 12]   = addr;
        ch_wdata[ch*32 +: 32]  = wdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; prev_yumi = 3'b000;
        rst = 1'b1; ch_valid = '0; ch_wen = '0; ch_bnw = '0;
        ch_addr = '0; ch_wdata = '0;
        mem_yumi_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

        // Reset state, with a request pending that must not be accepted
        repeat (2) @(negedge clk);
        issue(0, 1'b0, 1'b0, 12'h010, 32'h0);
        #2;
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_mem_valid", 32'(mem_valid_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_grant_id", 32'(grant_id_o), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr_o), 32'h0);
        chk("rst_yumi", 32'(ch_yumi_o), 32'h0);

        // 1: ch0 word load, ack after 2 SENT cycles, response 3 cycles after ack
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("t1_yumi", 32'(ch_yumi_o), 32'h1);
        @(negedge clk);
        ch_valid = '0;
        #2;
        chk("t1_mem_valid", 32'(mem_valid_o), 32'h1);
        chk("t1_mem_addr", 32'(mem_addr_o), 32'h010);
        chk("t1_mem_wen", 32'(mem_wen_o), 32'h0);
        chk("t1_busy", 32'(busy_o), 32'h1);
        @(negedge clk);
        #2;
        chk("t1_hold_valid", 32'(mem_valid_o), 32'h1);
        chk("t1_hold_addr", 32'(mem_addr_o), 32'h010);
        @(negedge clk);
        mem_yumi_i = 1'b1;
        @(negedge clk);
        mem_yumi_i = 1'b0;
        #2;
        chk("t1_acked_valid", 32'(mem_valid_o), 32'h0);
        chk("t1_acked_busy", 32'(busy_o), 32'h1);
        @(negedge clk);
        @(negedge clk);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEADBEEF;
        sb.push_back('{0, 32'hDEADBEEF});
        #2;
        chk("t1_mem_yumi", 32'(mem_yumi_o), 32'h1);
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        #2;
        chk("t1_idle", 32'(busy_o), 32'h0);

        // 2: all channels valid continuously, zero-latency memory
        do_reset();
        grant_log.delete();
        issue(0, 1'b0, 1'b0, 12'h100, 32'h0);
        issue(1, 1'b0, 1'b0, 12'h200, 32'h0);
        issue(2, 1'b0, 1'b0, 12'h300, 32'h0);
        for (int k = 0; k < 6; k++) begin
            wait_mv("t2_wait_valid");
            chk("t2_grant_id", 32'(grant_id_o), 32'(k % 3));
            chk("t2_mem_addr", 32'(mem_addr_o), 32'((k % 3 + 1) * 256));
            mem_yumi_i   = 1'b1;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hA000_0000 + 32'(k);
            sb.push_back('{k % 3, 32'hA000_0000 + 32'(k)});
            @(negedge clk);
            mem_yumi_i   = 1'b0;
            mem_rvalid_i = 1'b0;
            if (k == 5) ch_valid = '0;
        end
        #6;
        chk("t2_ngrants", 32'(grant_log.size()), 32'h6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++)
            chk("t2_order", 32'(grant_log[k]), 32'(k % 3));

        // 3: ch1 byte load, zero-extended result
        @(negedge clk);
        issue(1, 1'b0, 1'b1, 12'h055, 32'h0);
        wait_mv("t3_wait_valid");
        chk("t3_bnw", 32'(mem_bnw_o), 32'h1);
        chk("t3_addr", 32'(mem_addr_o), 32'h055);
        mem_yumi_i = 1'b1;
        @(negedge clk);
        mem_yumi_i   = 1'b0;
        ch_valid     = '0;
        ch_bnw       = '0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h12345678;
        sb.push_back('{1, 32'h00000078});
        #2;
        chk("t3_mem_yumi", 32'(mem_yumi_o), 32'h1);
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        #2;
        chk("t3_idle", 32'(busy_o), 32'h0);

        // 4: ack and response together in REQ_SENT
        @(negedge clk);
        issue(2, 1'b0, 1'b0, 12'h3F0, 32'h0);
        wait_mv("t4_wait_valid");
        ch_valid     = '0;
        mem_yumi_i   = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFEF00D;
        sb.push_back('{2, 32'hCAFEF00D});
        #2;
        chk("t4_mem_yumi", 32'(mem_yumi_o), 32'h1);
        chk("t4_rvalid", 32'(ch_rvalid_o), 32'h4);
        @(negedge clk);
        mem_yumi_i   = 1'b0;
        mem_rvalid_i = 1'b0;
        #2;
        chk("t4_busy_next", 32'(busy_o), 32'h0);

        // 5: store with no response trips the timeout
        @(negedge clk);
        issue(0, 1'b1, 1'b0, 12'h0AA, 32'h11223344);
        wait_mv("t5_wait_valid");
        chk("t5_wen", 32'(mem_wen_o), 32'h1);
        chk("t5_wdata", mem_wdata_o, 32'h11223344);
        mem_yumi_i = 1'b1;
        @(negedge clk);
        mem_yumi_i = 1'b0;
        ch_valid   = '0;
        ch_wen     = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("t5_err_early", 32'(err_o), 32'h0);
        chk("t5_busy_early", 32'(busy_o), 32'h1);
        @(negedge clk);
        #2;
        chk("t5_err_set", 32'(err_o), 32'h1);
        chk("t5_idle", 32'(busy_o), 32'h0);
        @(negedge clk);
        issue(1, 1'b0, 1'b0, 12'h123, 32'h0);
        wait_mv("t5_wait_valid2");
        ch_valid     = '0;
        mem_yumi_i   = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h55AA55AA;
        sb.push_back('{1, 32'h55AA55AA});
        @(negedge clk);
        mem_yumi_i   = 1'b0;
        mem_rvalid_i = 1'b0;
        #2;
        chk("t5_err_sticky", 32'(err_o), 32'h1);

        // 6: reset in REQ_SENT abandons the request; stray response is drained
        @(negedge clk);
        issue(2, 1'b0, 1'b0, 12'h777, 32'h0);
        wait_mv("t6_wait_valid");
        rst      = 1'b1;
        ch_valid = '0;
        #2;
        chk("t6_valid_drop", 32'(mem_valid_o), 32'h0);
        chk("t6_busy", 32'(busy_o), 32'h0);
        chk("t6_err_clr", 32'(err_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0BAD0;
        #2;
        chk("t6_stray_yumi", 32'(mem_yumi_o), 32'h1);
        chk("t6_no_rvalid", 32'(ch_rvalid_o), 32'h0);
        chk("t6_rdata_zero", ch_rdata_o, 32'h0);
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        repeat (2) @(negedge clk);
        #6;
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
